// File: rtl/bus_pkg.sv
// bus_pkg: shared burst-bus state encoding and burst geometry
package bus_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, BEAT, TURN} bus_state_t;
  localparam int BURSTLEN = 4;
  localparam int BEATBITS = 2;
endpackage

// File: rtl/bus_word_ram.sv
// bus_word_ram: WORDS x 32 store; sync write (clk, we, addr, wdata), async read (rdata)
module bus_word_ram #(
  parameter int WORDS = 1024,
  localparam int AW = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [WORDS];
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
  assign rdata = mem[addr];
endmodule

// File: rtl/bus_burst_responder.sv
// bus_burst_responder: 4-beat block responder; clk, reset(n), HRequest/HWrite/HAddr/HWData in, HRData/BusReady out
module bus_burst_responder
  import bus_pkg::*;
#(
  parameter int WAITCYCLES = 2,
  parameter int MEMWORDS   = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        HRequest,
  input  logic        HWrite,
  input  logic [31:0] HAddr,
  input  logic [31:0] HWData,
  output logic [31:0] HRData,
  output logic        BusReady
);
  localparam int AW = $clog2(MEMWORDS);
  bus_state_t state;
  logic [27:0] blk;
  logic wr;
  logic [BEATBITS-1:0] beat;
  logic [3:0] wcnt;
  logic [29:0] word;
  logic [31:0] rdata;
  logic unused_bits;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      blk <= '0;
      wr <= 1'b0;
      beat <= '0;
      wcnt <= '0;
    end else
      case (state)
        IDLE:
          if (HRequest) begin
            blk <= HAddr[31:4];
            wr <= HWrite;
            beat <= '0;
            wcnt <= 4'(WAITCYCLES);
            state <= WAITCYCLES == 0 ? BEAT : WAIT;
          end
        WAIT: begin
          wcnt <= wcnt - 4'd1;
          state <= !HRequest ? IDLE : wcnt == 4'd1 ? BEAT : WAIT;
        end
        BEAT:
          if (!HRequest) state <= IDLE;
          else if (beat == BEATBITS'(BURSTLEN - 1)) state <= TURN;
          else beat <= beat + 1'b1;
        default: state <= IDLE;
      endcase
  // gating with HRequest drops the strobe (and any write) in the abort cycle itself
  assign BusReady = state == BEAT && HRequest;
  assign HRData = BusReady && !wr ? rdata : '0;
  assign word = {blk, beat};
  assign unused_bits = ^{HAddr[3:0], word};
  bus_word_ram #(.WORDS(MEMWORDS)) ram (
    .clk(clk),
    .we(BusReady && wr),
    .addr(word[AW-1:0]),
    .wdata(HWData),
    .rdata(rdata)
  );
endmodule

// File: tb/tb_bus_burst_responder.sv
// tb_bus_burst_responder: directed checks on a 2-wait 1024-word and a 0-wait 16-word responder
module tb_bus_burst_responder;
  logic clk = 1'b0;
  logic rst_n [2];
  logic req [2];
  logic hw [2];
  logic [31:0] ha [2];
  logic [31:0] hwd [2];
  logic [31:0] hrd [2];
  logic br [2];
  logic [31:0] wd [4];
  logic [31:0] ed [4];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  bus_burst_responder #(.WAITCYCLES(2), .MEMWORDS(1024)) dut0 (
    .clk(clk), .reset(rst_n[0]), .HRequest(req[0]), .HWrite(hw[0]), .HAddr(ha[0]),
    .HWData(hwd[0]), .HRData(hrd[0]), .BusReady(br[0])
  );
  bus_burst_responder #(.WAITCYCLES(0), .MEMWORDS(16)) dut1 (
    .clk(clk), .reset(rst_n[1]), .HRequest(req[1]), .HWrite(hw[1]), .HAddr(ha[1]),
    .HWData(hwd[1]), .HRData(hrd[1]), .BusReady(br[1])
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic burst(input int s, input logic w, input logic [31:0] a, input bit hold, input string nm);
    int nw;
    nw = s == 0 ? 2 : 0;
    req[s] = 1'b1;
    hw[s] = w;
    ha[s] = a;
    hwd[s] = '0;
    #1;
    if (br[s] !== 1'b0) begin errors++; $display("FAIL %s idle ready got %b want 0", nm, br[s]); end
    checks++;
    for (int c = 0; c < nw; c++) begin
      tick;
      hw[s] = ~w;
      ha[s] = ~a;
      #1;
      if (br[s] !== 1'b0 || hrd[s] !== 32'h0) begin
        errors++; $display("FAIL %s wait%0d ready/data got %b/%h want 0/0", nm, c, br[s], hrd[s]);
      end
      checks++;
    end
    for (int b = 0; b < 4; b++) begin
      tick;
      hwd[s] = wd[b];
      hw[s] = ~w;
      ha[s] = ~a;
      #1;
      if (br[s] !== 1'b1) begin errors++; $display("FAIL %s beat%0d ready got %b want 1", nm, b, br[s]); end
      checks++;
      if (hrd[s] !== (w ? 32'h0 : ed[b])) begin
        errors++; $display("FAIL %s beat%0d data got %h want %h", nm, b, hrd[s], w ? 32'h0 : ed[b]);
      end
      checks++;
    end
    tick;
    if (br[s] !== 1'b0 || hrd[s] !== 32'h0) begin
      errors++; $display("FAIL %s turn ready/data got %b/%h want 0/0", nm, br[s], hrd[s]);
    end
    checks++;
    if (!hold) req[s] = 1'b0;
    tick;
  endtask
  task automatic test_reset;
    for (int s = 0; s < 2; s++) begin
      rst_n[s] = 1'b0; req[s] = 1'b1; hw[s] = 1'b0; ha[s] = '0; hwd[s] = '0;
    end
    tick;
    tick;
    for (int s = 0; s < 2; s++) begin
      if (br[s] !== 1'b0 || hrd[s] !== 32'h0) begin
        errors++; $display("FAIL reset%0d ready/data got %b/%h want 0/0", s, br[s], hrd[s]);
      end
      checks++;
      req[s] = 1'b0;
      rst_n[s] = 1'b1;
    end
    tick;
  endtask
  task automatic test_read;
    wd = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003, 32'hDDDD_0004};
    burst(0, 1'b1, 32'h40, 0, "preload40");
    ed = wd;
    burst(0, 1'b0, 32'h40, 0, "read40");
  endtask
  task automatic test_write_low_bits;
    wd = '{32'h1, 32'h2, 32'h3, 32'h4};
    burst(0, 1'b1, 32'h7C, 0, "write7c");
    ed = wd;
    burst(0, 1'b0, 32'h70, 0, "read70");
  endtask
  task automatic test_back_to_back;
    wd = '{32'hE0, 32'hE1, 32'hE2, 32'hE3};
    burst(0, 1'b1, 32'h200, 0, "preload200");
    wd = '{32'h5, 32'h6, 32'h7, 32'h8};
    burst(0, 1'b1, 32'h100, 1, "b2b_wb100");
    ed = '{32'hE0, 32'hE1, 32'hE2, 32'hE3};
    burst(0, 1'b0, 32'h200, 0, "b2b_fill200");
    ed = '{32'h5, 32'h6, 32'h7, 32'h8};
    burst(0, 1'b0, 32'h100, 0, "read100");
  endtask
  task automatic test_abort;
    wd = '{32'h9, 32'hA, 32'hB, 32'hC};
    burst(0, 1'b1, 32'h300, 0, "preload300");
    req[0] = 1'b1; hw[0] = 1'b1; ha[0] = 32'h300;
    tick;
    tick;
    for (int b = 0; b < 2; b++) begin
      tick;
      hwd[0] = 32'h11 + 32'(b);
      #1;
      if (br[0] !== 1'b1) begin errors++; $display("FAIL abort beat%0d ready got %b want 1", b, br[0]); end
      checks++;
    end
    tick;
    req[0] = 1'b0;
    hwd[0] = 32'h13;
    #1;
    if (br[0] !== 1'b0) begin errors++; $display("FAIL abort drop ready got %b want 0", br[0]); end
    checks++;
    tick;
    if (br[0] !== 1'b0) begin errors++; $display("FAIL abort idle ready got %b want 0", br[0]); end
    checks++;
    ed = '{32'h11, 32'h12, 32'hB, 32'hC};
    burst(0, 1'b0, 32'h300, 0, "abort_read300");
  endtask
  task automatic test_wait0_reset;
    wd = '{32'h21, 32'h22, 32'h23, 32'h24};
    burst(1, 1'b1, 32'h0, 0, "w0_write0");
    req[1] = 1'b1; hw[1] = 1'b1; ha[1] = 32'h0;
    for (int b = 0; b < 2; b++) begin
      tick;
      hwd[1] = 32'h31 + 32'(b);
      #1;
      if (br[1] !== 1'b1) begin errors++; $display("FAIL w0rst beat%0d ready got %b want 1", b, br[1]); end
      checks++;
    end
    tick;
    hwd[1] = 32'h33;
    rst_n[1] = 1'b0;
    #1;
    if (br[1] !== 1'b0 || hrd[1] !== 32'h0) begin
      errors++; $display("FAIL w0rst async ready/data got %b/%h want 0/0", br[1], hrd[1]);
    end
    checks++;
    tick;
    rst_n[1] = 1'b1;
    req[1] = 1'b0;
    tick;
    ed = '{32'h31, 32'h32, 32'h23, 32'h24};
    burst(1, 1'b0, 32'h100, 0, "w0_read_wrap100");
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    test_reset;
    test_read;
    test_write_low_bits;
    test_back_to_back;
    test_abort;
    test_wait0_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bus_burst_responder.md
BUS_BURST_RESPONDER -- requirements
Module: bus_burst_responder

Interface
REQ-001 Parameter WAITCYCLES, default 2: idle cycles between burst acceptance and the first data beat; legal range 0..15.
REQ-002 Parameter MEMWORDS, default 1024: depth of the backing store in 32-bit words; must be a power of two and at least 4.
REQ-003 clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 reset  in  1  active-low, asynchronous reset.
REQ-005 HRequest  in  1  initiator requests a 4-word block transfer; held high for the whole transfer.
REQ-006 HWrite  in  1  1 = writeback burst, 0 = fill (read) burst; sampled at burst acceptance only.
REQ-007 HAddr  in  32  byte address; bits [31:4] select the block, bits [3:0] are ignored.
REQ-008 HWData  in  32  write data for the current beat.
REQ-009 HRData  out  32  read data for the current beat.
REQ-010 BusReady  out  1  beat-complete strobe; the initiator's word counter advances on each high cycle.

Function
REQ-011 States: IDLE, WAIT, BEAT, TURN; the enum lives in the shared package.
REQ-012 IDLE, HRequest=1: latch HAddr[31:4] and HWrite, clear BeatCnt, load WaitCnt=WAITCYCLES.
  - WAITCYCLES>0: next state is WAIT.
  - WAITCYCLES=0: next state is BEAT.
REQ-013 WAIT: decrement WaitCnt each cycle; go to BEAT in the cycle after WaitCnt reaches 1.
REQ-014 BEAT: BusReady=1 every cycle; BeatCnt increments 0->1->2->3; after beat 3, go to TURN.
REQ-015 Beat word address = {latched block, BeatCnt}, taken modulo MEMWORDS (upper bits truncated, no error).
REQ-016 Read burst: HRData = mem[beat address] combinationally while BusReady=1; otherwise HRData=0.
REQ-017 Write burst: mem[beat address] <= HWData on each clock edge with BusReady=1; full-word write, no byte mask.
REQ-018 TURN: BusReady=0 for exactly one cycle, then IDLE.
  - Back-to-back transfers (writeback then fill) therefore re-enter IDLE, and the new burst is accepted the following cycle.
REQ-019 Burst latency: first BusReady occurs WAITCYCLES+1 cycles after the cycle in which HRequest rises in IDLE; a full burst occupies WAITCYCLES+6 cycles from acceptance through TURN.
REQ-020 HRequest low in WAIT or BEAT: abort to IDLE next cycle.
  - BusReady=0 from the abort cycle onward; no further memory writes.
  - Beats already written are retained.
REQ-021 Changes to HWrite or HAddr after acceptance have no effect until the next burst.
REQ-022 Exactly 4 BusReady pulses per completed burst; BeatCnt wraps 3->0 only via re-acceptance.

Reset
REQ-023 reset low asynchronously forces:
  - state to IDLE;
  - BeatCnt, WaitCnt, the latched block and the latched HWrite to 0;
  - BusReady=0 and HRData=0.
REQ-024 Memory contents are not reset.
REQ-025 Reset asserted mid-burst terminates the burst with no further writes.

Structure
REQ-026 Package bus_pkg holds the state typedef, BURSTLEN=4 and BEATBITS=2; the initiator-side cache controllers import the same package.
REQ-027 Storage is one sub-module, bus_word_ram: MEMWORDS x 32, one synchronous write port, one asynchronous read port.
REQ-028 The FSM and the counters stay in bus_burst_responder.

Verification
REQ-029 Cover these directed scenarios:
  - Reset, then a read burst at HAddr=0x40 with mem[16..19]=A,B,C,D and WAITCYCLES=2 -> BusReady high on cycles 3-6 after acceptance, HRData=A,B,C,D, then one TURN cycle.
  - Write burst at HAddr=0x7C with HWData=1,2,3,4 -> mem[28..31]=1,2,3,4; HAddr[3:0] ignored.
  - Writeback to 0x100 immediately followed by a fill from 0x200 with HRequest held high -> two 4-beat bursts separated by TURN+IDLE; fill returns mem[128..131].
  - HRequest dropped after beat 1 of a write burst -> only 2 words written, BusReady low the next cycle, state IDLE.
  - WAITCYCLES=0 -> BusReady high the cycle after acceptance; reset asserted during beat 2 -> BusReady=0 immediately and beat 2 not written.
